// File: rtl/sync_decoder.sv
// Video sync decoder: measures line/frame timing from async h/v sync and tracks lock.
// Optional SYNC_DECODER_GLITCH_FILTER_EN adds a 3-sample majority filter on each synced input.
module sync_decoder #(
  parameter int H_W         = 11,
  parameter int V_W         = 10,
  parameter int LOCK_FRAMES = 2
) (
  input  logic           osc_clk,
  input  logic           RESET,
  input  logic           h_sync_in,
  input  logic           v_sync_in,
  output logic [H_W-1:0] pix_x,
  output logic [V_W-1:0] pix_y,
  output logic [H_W-1:0] h_total,
  output logic [V_W-1:0] v_total,
  output logic           locked,
  output logic           frame_start,
  output logic           lock_lost
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [H_W-1:0] X_ONE  = {{(H_W-1){1'b0}}, 1'b1};
  localparam logic [V_W-1:0] Y_ONE  = {{(V_W-1){1'b0}}, 1'b1};
  localparam logic [2:0]     LOCK_N = 3'(LOCK_FRAMES);

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge osc_clk or negedge RESET) begin
    if (!RESET) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n_int = rst_sync_q[1];

  logic [1:0] hs_meta_q, vs_meta_q;
  logic       hs_lvl, vs_lvl;
  logic       hs_prev_q, vs_prev_q;
  logic       hs_start, vs_start;

  always_ff @(posedge osc_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      hs_meta_q <= '1;
      vs_meta_q <= '1;
    end else begin
      hs_meta_q <= {hs_meta_q[0], h_sync_in};
      vs_meta_q <= {vs_meta_q[0], v_sync_in};
    end
  end

`ifdef SYNC_DECODER_GLITCH_FILTER_EN
  logic [1:0] hs_win_q, vs_win_q;
  logic       hs_filt_q, vs_filt_q;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge osc_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      hs_win_q  <= '1;
      vs_win_q  <= '1;
      hs_filt_q <= 1'b1;
      vs_filt_q <= 1'b1;
    end else begin
      hs_win_q  <= {hs_win_q[0], hs_meta_q[1]};
      vs_win_q  <= {vs_win_q[0], vs_meta_q[1]};
      hs_filt_q <= maj3(hs_meta_q[1], hs_win_q[0], hs_win_q[1]);
      vs_filt_q <= maj3(vs_meta_q[1], vs_win_q[0], vs_win_q[1]);
    end
  end

  assign hs_lvl = hs_filt_q;
  assign vs_lvl = vs_filt_q;
`else
  assign hs_lvl = hs_meta_q[1];
  assign vs_lvl = vs_meta_q[1];
`endif

  assign hs_start = hs_prev_q & ~hs_lvl;
  assign vs_start = vs_prev_q & ~vs_lvl;

  state_t         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d, cnt_inc;
  logic [H_W-1:0] pix_x_q, pix_x_d, h_total_q, h_total_d, ref_q, ref_d;
  logic [V_W-1:0] pix_y_q, pix_y_d, v_total_q, v_total_d;
  logic           first_q, first_d, bad_q, bad_d;
  logic           locked_q, frame_start_q, frame_start_d, lock_lost_q, lock_lost_d;
  logic           sat, line_bad, frame_ok, loss;
  logic [H_W-1:0] x_inc;
  logic [V_W-1:0] y_inc, pyi;

  always_comb begin
    sat      = &pix_x_q;
    x_inc    = sat ? pix_x_q : pix_x_q + X_ONE;
    y_inc    = (&pix_y_q) ? pix_y_q : pix_y_q + Y_ONE;
    // Line count as it stands after this cycle's line start, so a coincident hs is counted.
    pyi      = hs_start ? y_inc : pix_y_q;
    line_bad = hs_start & ~first_q & (x_inc != ref_q);
    frame_ok = ~(bad_q | line_bad) & (pyi == v_total_q);
    loss     = sat | (hs_start & (x_inc != h_total_q)) | (vs_start & (pyi != v_total_q));
    cnt_inc  = cnt_q + 3'd1;

    pix_x_d   = hs_start ? '0 : x_inc;
    pix_y_d   = vs_start ? '0 : pyi;
    h_total_d = hs_start ? x_inc : h_total_q;
    v_total_d = vs_start ? pyi : v_total_q;

    first_d = first_q;
    bad_d   = bad_q;
    ref_d   = ref_q;
    if (vs_start) begin
      first_d = 1'b1;
      bad_d   = 1'b0;
    end else if (hs_start) begin
      if (first_q) begin
        ref_d   = x_inc;
        first_d = 1'b0;
      end else begin
        bad_d = bad_q | line_bad;
      end
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      SEARCH: begin
        cnt_d = '0;
        if (!sat && vs_start) state_d = MEASURE;
      end
      MEASURE: begin
        if (sat) begin
          state_d = SEARCH;
          cnt_d   = '0;
        end else if (vs_start) begin
          if (!frame_ok) begin
            cnt_d = '0;
          end else if (cnt_inc >= LOCK_N) begin
            state_d = LOCKED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      LOCKED: begin
        if (loss) begin
          state_d = SEARCH;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = SEARCH;
        cnt_d   = '0;
      end
    endcase

    frame_start_d = vs_start & (state_q == LOCKED) & (state_d == LOCKED);
    lock_lost_d   = (state_q == LOCKED) & (state_d == SEARCH);
  end

  always_ff @(posedge osc_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      hs_prev_q     <= 1'b1;
      vs_prev_q     <= 1'b1;
      state_q       <= SEARCH;
      cnt_q         <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      h_total_q     <= '0;
      v_total_q     <= '0;
      ref_q         <= '0;
      first_q       <= 1'b1;
      bad_q         <= 1'b0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      lock_lost_q   <= 1'b0;
    end else begin
      hs_prev_q     <= hs_lvl;
      vs_prev_q     <= vs_lvl;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      h_total_q     <= h_total_d;
      v_total_q     <= v_total_d;
      ref_q         <= ref_d;
      first_q       <= first_d;
      bad_q         <= bad_d;
      locked_q      <= (state_d == LOCKED);
      frame_start_q <= frame_start_d;
      lock_lost_q   <= lock_lost_d;
    end
  end

  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign h_total     = h_total_q;
  assign v_total     = v_total_q;
  assign locked      = locked_q;
  assign frame_start = frame_start_q;
  assign lock_lost   = lock_lost_q;

endmodule

// File: tb/tb_sync_decoder.sv
// Self-checking bench for sync_decoder: directed timing scenarios plus randomized frames,
// every cycle compared against a rule-level model of line/frame measurement and lock.
module tb_sync_decoder;

  localparam int H_W  = 11;
  localparam int V_W  = 10;
  localparam int LF   = 2;
  localparam int MAXX = (1 << H_W) - 1;
  localparam int MAXY = (1 << V_W) - 1;
  localparam int S_SEARCH  = 0;
  localparam int S_MEASURE = 1;
  localparam int S_LOCKED  = 2;

`ifdef SYNC_DECODER_GLITCH_FILTER_EN
  localparam int GL_LOCK_EXP = 1;
  localparam int GL_LL_EXP   = 0;
`else
  localparam int GL_LOCK_EXP = 0;
  localparam int GL_LL_EXP   = 1;
`endif

  logic           osc_clk = 1'b0;
  logic           RESET = 1'b0;
  logic           h_sync_in = 1'b1;
  logic           v_sync_in = 1'b1;
  logic [H_W-1:0] pix_x;
  logic [V_W-1:0] pix_y;
  logic [H_W-1:0] h_total;
  logic [V_W-1:0] v_total;
  logic           locked;
  logic           frame_start;
  logic           lock_lost;

  int n_tests = 0;
  int n_fail  = 0;

  sync_decoder #(.H_W(H_W), .V_W(V_W), .LOCK_FRAMES(LF)) dut (
    .osc_clk    (osc_clk),
    .RESET      (RESET),
    .h_sync_in  (h_sync_in),
    .v_sync_in  (v_sync_in),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .h_total    (h_total),
    .v_total    (v_total),
    .locked     (locked),
    .frame_start(frame_start),
    .lock_lost  (lock_lost)
  );

  always #5 osc_clk = ~osc_clk;

  // Reference model state
  bit hh[$];
  bit vh[$];
  int lens[$];
  int m_px, m_py, m_ht, m_vt, m_st, m_cnt, m_dead;
  bit m_fs, m_ll, m_lk;

  int cycle = 0;
  int ll_seen = 0;
  bit fs_log_en = 1'b0;
  int fs_log[$];
  bit vlev = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  function automatic bit maj(input bit a, input bit b, input bit c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic int sat_add(input int v, input int mx);
    return (v + 1 > mx) ? mx : v + 1;
  endfunction

  task automatic model_reset();
    m_px = 0; m_py = 0; m_ht = 0; m_vt = 0;
    m_st = S_SEARCH; m_cnt = 0;
    m_fs = 0; m_ll = 0; m_lk = 0;
    lens.delete(); hh.delete(); vh.delete();
    for (int i = 0; i < 8; i++) begin
      hh.push_back(1'b1);
      vh.push_back(1'b1);
    end
    m_dead = 2;
  endtask

  task automatic model_step(input bit h, input bit v);
    bit hs, vs, sat, ok, loss;
    int len, pyi, ns;
    if (m_dead > 0) begin
      m_dead--;
      return;
    end
    hh.push_front(h); void'(hh.pop_back());
    vh.push_front(v); void'(vh.pop_back());
`ifdef SYNC_DECODER_GLITCH_FILTER_EN
    hs = !maj(hh[3], hh[4], hh[5]) && maj(hh[4], hh[5], hh[6]);
    vs = !maj(vh[3], vh[4], vh[5]) && maj(vh[4], vh[5], vh[6]);
`else
    hs = !hh[2] && hh[3];
    vs = !vh[2] && vh[3];
`endif
    sat = (m_px == MAXX);
    len = sat_add(m_px, MAXX);
    pyi = hs ? sat_add(m_py, MAXY) : m_py;
    ok  = 1'b1;
    if (hs) lens.push_back(len);
    if (vs) begin
      foreach (lens[i]) if (lens[i] != lens[0]) ok = 1'b0;
      if (pyi != m_vt) ok = 1'b0;
      lens.delete();
    end
    loss = sat || (hs && len != m_ht) || (vs && pyi != m_vt);
    ns = m_st;
    if (m_st == S_SEARCH) begin
      m_cnt = 0;
      if (!sat && vs) ns = S_MEASURE;
    end else if (m_st == S_MEASURE) begin
      if (sat) begin
        ns = S_SEARCH; m_cnt = 0;
      end else if (vs) begin
        m_cnt = ok ? m_cnt + 1 : 0;
        if (m_cnt >= LF) begin
          ns = S_LOCKED; m_cnt = 0;
        end
      end
    end else if (loss) begin
      ns = S_SEARCH; m_cnt = 0;
    end
    m_fs = vs && m_st == S_LOCKED && ns == S_LOCKED;
    m_ll = m_st == S_LOCKED && ns == S_SEARCH;
    m_lk = ns == S_LOCKED;
    m_px = hs ? 0 : len;
    m_py = vs ? 0 : pyi;
    if (hs) m_ht = len;
    if (vs) m_vt = pyi;
    m_st = ns;
  endtask

  task automatic cyc(input bit h, input bit v);
    h_sync_in = h;
    v_sync_in = v;
    @(posedge osc_clk);
    model_step(h, v);
    cycle++;
    @(negedge osc_clk);
    check("pix_x", 32'(pix_x), m_px);
    check("pix_y", 32'(pix_y), m_py);
    check("h_total", 32'(h_total), m_ht);
    check("v_total", 32'(v_total), m_vt);
    check("locked", 32'(locked), 32'(m_lk));
    check("frame_start", 32'(frame_start), 32'(m_fs));
    check("lock_lost", 32'(lock_lost), 32'(m_ll));
    if (frame_start && fs_log_en) fs_log.push_back(cycle);
    if (lock_lost) ll_seen++;
  endtask

  task automatic line(input int len, input int vfall, input int vrise, input int gpos, input int glen);
    bit h;
    for (int c = 0; c < len; c++) begin
      h = (c < 8) ? 1'b0 : 1'b1;
      if (gpos >= 0 && c >= gpos && c < gpos + glen) h = 1'b0;
      if (c == vfall) vlev = 1'b0;
      if (c == vrise) vlev = 1'b1;
      cyc(h, vlev);
    end
  endtask

  task automatic frame(input int voff, input int odd_line, input int odd_len,
                       input int gline, input int gpos, input int glen);
    for (int l = 0; l < 10; l++)
      line((l == odd_line) ? odd_len : 100, (l == 0) ? voff : -1, (l == 1) ? 50 : -1,
           (l == gline) ? gpos : -1, glen);
  endtask

  task automatic good_frame();
    frame(0, -1, 100, -1, -1, 0);
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    h_sync_in = 1'b1;
    v_sync_in = 1'b1;
    vlev = 1'b1;
    #1;
    check("rst_pix_x", 32'(pix_x), 0);
    check("rst_pix_y", 32'(pix_y), 0);
    check("rst_h_total", 32'(h_total), 0);
    check("rst_v_total", 32'(v_total), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_frame_start", 32'(frame_start), 0);
    check("rst_lock_lost", 32'(lock_lost), 0);
    model_reset();
    repeat (3) @(negedge osc_clk);
    RESET = 1'b1;
  endtask

  initial begin
    @(negedge osc_clk);
    do_reset();
    repeat (20) cyc(1'b1, 1'b1);

    // Nine lines without vsync so the first frame start sees a full frame's line count.
    for (int i = 0; i < 9; i++) line(100, -1, -1, -1, 0);
    good_frame();
    good_frame();
    check("lock_not_yet", 32'(locked), 0);
    good_frame();
    check("lock_acquired", 32'(locked), 1);
    check("h_total_100", 32'(h_total), 100);
    check("v_total_10", 32'(v_total), 10);

    fs_log_en = 1'b1;
    good_frame();
    good_frame();
    fs_log_en = 1'b0;
    check("fs_count", fs_log.size(), 2);
    if (fs_log.size() >= 2) check("fs_period", fs_log[1] - fs_log[0], 1000);

    // Shortened line while locked
    ll_seen = 0;
    frame(0, 5, 99, -1, -1, 0);
    check("short_lock_lost", ll_seen, 1);
    check("short_unlocked", 32'(locked), 0);
    good_frame();
    good_frame();
    check("relock_pending", 32'(locked), 0);
    good_frame();
    check("relocked", 32'(locked), 1);

    // hsync stall: pix_x saturates, no wrap
    ll_seen = 0;
    repeat (3000) cyc(1'b1, 1'b1);
    check("stall_pix_x", 32'(pix_x), MAXX);
    check("stall_unlocked", 32'(locked), 0);
    check("stall_lock_lost", ll_seen, 1);
    for (int i = 0; i < 4; i++) good_frame();
    check("coinc_locked", 32'(locked), 1);
    check("coinc_v_total", 32'(v_total), 10);
    check("coinc_h_total", 32'(h_total), 100);

    // Reset mid-frame while locked
    line(100, 0, -1, -1, 0);
    line(100, -1, 50, -1, 0);
    for (int i = 0; i < 3; i++) line(100, -1, -1, -1, 0);
    @(negedge osc_clk);
    do_reset();
    repeat (20) cyc(1'b1, 1'b1);
    good_frame();
    good_frame();
    check("post_reset_no_lock", 32'(locked), 0);
    for (int i = 0; i < 3; i++) good_frame();
    check("post_reset_relock", 32'(locked), 1);

    // Single-cycle hsync glitch while locked
    ll_seen = 0;
    frame(0, -1, 100, 4, 40, 1);
    check("glitch_locked", 32'(locked), GL_LOCK_EXP);
    check("glitch_lock_lost", ll_seen, GL_LL_EXP);

    // Randomized frames
    for (int f = 0; f < 15; f++) begin
      int voff, oline, olen, gline, gpos, glen;
      voff  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 30);
      oline = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 9) : -1;
      olen  = $urandom_range(95, 105);
      gline = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 9) : -1;
      gpos  = $urandom_range(20, 80);
      glen  = $urandom_range(1, 2);
      frame(voff, oline, olen, gline, gpos, glen);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_decoder.md
SYNC_DECODER -- requirements
Module: sync_decoder

Interface
REQ-001 Parameter H_W, default 11, width of horizontal cycle counter and measured line length.
REQ-002 Parameter V_W, default 10, width of line counter and measured frame height.
REQ-003 Parameter LOCK_FRAMES, default 2, consecutive matching frames required to declare lock (range 1..7).
REQ-004 osc_clk  input  1  sole clock; all logic rising-edge.
REQ-005 RESET  input  1  asynchronous, active-low reset.
REQ-006 h_sync_in  input  1  horizontal sync, active-low, asynchronous to osc_clk.
REQ-007 v_sync_in  input  1  vertical sync, active-low, asynchronous to osc_clk.
REQ-008 pix_x  output  H_W  cycles since last line start.
REQ-009 pix_y  output  V_W  lines since last frame start.
REQ-010 h_total  output  H_W  last captured line length in osc_clk cycles.
REQ-011 v_total  output  V_W  last captured lines per frame.
REQ-012 locked  output  1  high while state is LOCKED.
REQ-013 frame_start  output  1  one-cycle pulse on each frame start while LOCKED.
REQ-014 lock_lost  output  1  one-cycle pulse on LOCKED->SEARCH transition.

Function
REQ-015 Each sync input SHALL pass a 2-flop synchronizer; line start (hs_start) = synchronized h_sync falling edge; frame start (vs_start) = synchronized v_sync falling edge; hs_start asserts 3 cycles after the input edge.
REQ-016 pix_x SHALL increment every cycle, load 0 the cycle after hs_start, and saturate at all-ones (no wrap).
REQ-017 On hs_start, h_total SHALL capture pix_x+1; pix_y SHALL increment, saturating at all-ones.
REQ-018 On vs_start, v_total SHALL capture pix_y and pix_y SHALL load 0; if hs_start coincides, pix_y loads 0 (vs wins), pix_x behaves per REQ-016.
REQ-019 States: SEARCH, MEASURE, LOCKED; SEARCH->MEASURE on first vs_start.
REQ-020 MEASURE: at each vs_start, a frame matches when every line length in the frame equalled the first line's and frame height equals previous v_total; match counter increments, mismatch clears it; counter reaching LOCK_FRAMES -> LOCKED.
REQ-021 LOCKED: hs_start with pix_x+1 != h_total, vs_start with pix_y != v_total, or pix_x saturation -> SEARCH and pulse lock_lost that cycle.
REQ-022 MEASURE or SEARCH: pix_x saturation -> SEARCH, match counter cleared, no lock_lost pulse.
REQ-023 frame_start SHALL pulse in the cycle vs_start is processed only when state is LOCKED before and after that cycle.
REQ-024 h_total/v_total SHALL update in every state; locked is registered, valid the cycle after the transition.

Reset
REQ-025 RESET low SHALL asynchronously force SEARCH, all counters, h_total, v_total, synchronizers (to 1, sync idle) and all outputs to 0.
REQ-026 Release SHALL be synchronized; no hs_start/vs_start SHALL be generated from the reset-release edge; reset mid-frame discards all lock history.

Configuration
REQ-027 Macro SYNC_DECODER_GLITCH_FILTER_EN: when defined, each synchronized sync SHALL pass a 3-sample majority filter (adds 2 cycles to REQ-015 latency; pulses shorter than 2 cycles ignored); when undefined, no filter and latency is exactly 3 cycles.

Verification
REQ-028 Lines 100 cycles, frames 10 lines, hsync low 8 cycles -> h_total=100, v_total=10, locked high after 1 (SEARCH) + LOCK_FRAMES=2 matching frames, frame_start every 1000 cycles.
REQ-029 Locked, one line shortened to 99 cycles -> lock_lost pulse at that hs_start, locked low, relock after 3 further good frames.
REQ-030 hsync stopped for 3000 cycles -> pix_x holds 2047, state SEARCH, no counter wrap.
REQ-031 hs and vs falling edges same cycle -> pix_y=0, h_total captured normally, v_total=10.
REQ-032 RESET asserted mid-frame while locked -> all outputs 0 immediately; after release full relock sequence required.
REQ-033 Filter macro defined, 1-cycle low glitch on h_sync_in -> no hs_start, lock retained; undefined -> lock_lost.
